// File: rtl/ahb_lite_timer.sv
// Zero-wait AHB-Lite down-counting timer: prescaler, auto/one-shot reload, level IRQ.
// Optional COMPARE register and PWM output are built when TIMER_PWM_EN is defined.
module ahb_lite_timer #(
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [31:0] RST_LOAD       = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        IRQ,
  output logic        PWM_OUT
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_LOAD     = 3'd1;
  localparam logic [2:0] A_VALUE    = 3'd2;
  localparam logic [2:0] A_PRESCALE = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;
  localparam logic [2:0] A_COMPARE  = 3'd5;

  logic                      r_ap_vld;
  logic [2:0]                r_ap_addr;
  logic                      r_ap_write;
  logic [2:0]                r_ctrl;
  logic [31:0]               r_load;
  logic [31:0]               r_value;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic                      r_if;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_prescale;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_underflow;
  logic [31:0] w_compare_rd;
  logic [31:0] w_rdata;
  logic        w_unused_ok;

  assign w_wr          = r_ap_vld & r_ap_write;
  assign w_wr_ctrl     = w_wr & (r_ap_addr == A_CTRL);
  assign w_wr_load     = w_wr & (r_ap_addr == A_LOAD);
  assign w_wr_prescale = w_wr & (r_ap_addr == A_PRESCALE);
  assign w_wr_status   = w_wr & (r_ap_addr == A_STATUS);

  // >= rather than == so shrinking PRESCALE below the running count cannot stall for a full wrap
  assign w_tick      = r_ctrl[0] & (r_pcnt >= r_prescale);
  assign w_underflow = w_tick & (r_value == 32'd0) & ~w_wr_load;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ap_vld   <= 1'b0;
      r_ap_addr  <= 3'd0;
      r_ap_write <= 1'b0;
      r_ctrl     <= 3'd0;
      r_load     <= RST_LOAD;
      r_value    <= RST_LOAD;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_if       <= 1'b0;
    end else begin
      r_ap_vld   <= HSEL & HREADY & HTRANS[1];
      r_ap_addr  <= HADDR[4:2];
      r_ap_write <= HWRITE;

      if (w_wr_ctrl)
        r_ctrl <= HWDATA[2:0];
      else if (w_underflow && r_ctrl[2])
        r_ctrl[0] <= 1'b0;

      if (w_wr_load)
        r_load <= HWDATA;

      if (w_wr_prescale)
        r_prescale <= HWDATA[PRESCALE_WIDTH-1:0];

      if (w_wr_load)
        r_pcnt <= '0;
      else if (r_ctrl[0])
        r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_WIDTH'(1);

      // a LOAD write overrides any decrement or reload on the same edge
      if (w_wr_load)
        r_value <= HWDATA;
      else if (w_tick) begin
        if (r_value != 32'd0)
          r_value <= r_value - 32'd1;
        else if (!r_ctrl[2])
          r_value <= r_load;
      end

      if (w_underflow)
        r_if <= 1'b1;
      else if (w_wr_status && HWDATA[0])
        r_if <= 1'b0;
    end
  end

`ifdef TIMER_PWM_EN
  logic [31:0] r_compare;
  logic        r_pwm;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_compare <= 32'd0;
      r_pwm     <= 1'b0;
    end else begin
      if (w_wr && (r_ap_addr == A_COMPARE))
        r_compare <= HWDATA;
      r_pwm <= r_ctrl[0] & (r_value < r_compare);
    end
  end

  assign w_compare_rd = r_compare;
  assign PWM_OUT      = r_pwm;
`else
  assign w_compare_rd = 32'd0;
  assign PWM_OUT      = 1'b0;
`endif

  always_comb begin
    w_rdata = 32'd0;
    if (r_ap_vld) begin
      case (r_ap_addr)
        A_CTRL:     w_rdata = {29'd0, r_ctrl};
        A_LOAD:     w_rdata = r_load;
        A_VALUE:    w_rdata = r_value;
        A_PRESCALE: w_rdata = 32'(r_prescale);
        A_STATUS:   w_rdata = {31'd0, r_if};
        A_COMPARE:  w_rdata = w_compare_rd;
        default:    w_rdata = 32'd0;
      endcase
    end
  end

  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = r_if & r_ctrl[1];

  assign w_unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HPROT};

endmodule

// File: tb/tb_ahb_lite_timer.sv
// Directed bench for ahb_lite_timer: bus pipelining, periodic/one-shot counting, IF collisions.
module tb_ahb_lite_timer;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        IRQ;
  logic        PWM_OUT;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] rd;
  int cnt;

  logic [31:0] per_exp [0:16] = '{3, 3, 2, 2, 1, 1, 0, 0, 3, 3, 2, 2, 1, 1, 0, 0, 3};
  logic [31:0] os_exp  [0:4]  = '{2, 1, 0, 0, 0};

  ahb_lite_timer dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .IRQ       (IRQ),
    .PWM_OUT   (PWM_OUT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = w;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    cyc();
    bus_idle();
    HWDATA = d;
    cyc();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_phase(a, 1'b0);
    cyc();
    bus_idle();
    d = HRDATA;
  endtask

  initial begin
    HRESET = 1'b1;
    bus_idle();
    HADDR  = 32'd0;
    HWDATA = 32'd0;
    HSIZE  = 3'b010;
    HPROT  = 4'd0;
    HREADY = 1'b1;
    repeat (2) cyc();
    HRESET = 1'b0;

    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_pwm", 32'(PWM_OUT), 32'd0);
    bus_read(32'h00, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(32'h04, rd); check("rst_load", rd, 32'd0);
    bus_read(32'h08, rd); check("rst_value", rd, 32'd0);

    // periodic: LOAD=3, PRESCALE=1, EN|IRQ_EN, VALUE streamed every cycle
    bus_write(32'h04, 32'd3);
    bus_write(32'h0C, 32'd1);
    bus_read(32'h0C, rd); check("per_prescale_rd", rd, 32'd1);
    addr_phase(32'h00, 1'b1);
    cyc();
    HWDATA = 32'h3;
    addr_phase(32'h08, 1'b0);
    cyc();
    for (int k = 0; k < 17; k++) begin
      check($sformatf("per_value_%0d", k), HRDATA, per_exp[k]);
      if (k == 7) check("per_irq_before", 32'(IRQ), 32'd0);
      if (k == 8) check("per_irq_at_reload", 32'(IRQ), 32'd1);
      if (k < 16) cyc();
    end
    bus_idle();
    bus_read(32'h10, rd); check("per_status", rd, 32'd1);

    // reset mid-count with LOAD=5 running
    bus_write(32'h04, 32'd5);
    repeat (3) cyc();
    HRESET = 1'b1;
    cyc();
    check("midrst_irq", 32'(IRQ), 32'd0);
    repeat (2) cyc();
    HRESET = 1'b0;
    bus_read(32'h00, rd); check("midrst_ctrl", rd, 32'd0);
    bus_read(32'h08, rd); check("midrst_value", rd, 32'd0);
    bus_read(32'h10, rd); check("midrst_status", rd, 32'd0);
    bus_read(32'h04, rd); check("midrst_load", rd, 32'd0);
    bus_read(32'h0C, rd); check("midrst_prescale", rd, 32'd0);
    check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(HRESP), 32'd0);

    // one-shot: LOAD=2, PRESCALE=0, CTRL=0x7
    bus_write(32'h04, 32'd2);
    addr_phase(32'h00, 1'b1);
    cyc();
    HWDATA = 32'h7;
    addr_phase(32'h08, 1'b0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("os_value_%0d", k), HRDATA, os_exp[k]);
      check($sformatf("os_irq_%0d", k), 32'(IRQ), (k >= 3) ? 32'd1 : 32'd0);
      if (k < 4) cyc();
    end
    bus_idle();
    bus_read(32'h00, rd); check("os_ctrl", rd, 32'd6);
    bus_read(32'h10, rd); check("os_status", rd, 32'd1);

    // STATUS W1C colliding with underflow every cycle (LOAD=0, PRESCALE=0)
    bus_write(32'h04, 32'd0);
    bus_write(32'h00, 32'd3);
    bus_write(32'h10, 32'd1);
    check("w1c_collision_irq", 32'(IRQ), 32'd1);
    bus_write(32'h00, 32'd2);
    bus_write(32'h10, 32'd0);
    check("w1c_zero_irq", 32'(IRQ), 32'd1);
    bus_write(32'h00, 32'd0);
    check("irq_masked", 32'(IRQ), 32'd0);
    bus_write(32'h00, 32'd2);
    check("irq_unmasked", 32'(IRQ), 32'd1);
    bus_write(32'h10, 32'd1);
    check("w1c_clear_irq", 32'(IRQ), 32'd0);
    bus_read(32'h10, rd); check("w1c_clear_status", rd, 32'd0);

    // pipelined write then read of LOAD
    addr_phase(32'h04, 1'b1);
    cyc();
    HWDATA = 32'h1234;
    addr_phase(32'h04, 1'b0);
    cyc();
    bus_idle();
    check("b2b_load", HRDATA, 32'h0000_1234);
    bus_read(32'h08, rd); check("load_sets_value", rd, 32'h1234);
    bus_read(32'h18, rd); check("unmapped_rd", rd, 32'd0);

    // IDLE transfer with HSEL/HWRITE high must not write
    HSEL   = 1'b1;
    HTRANS = 2'b00;
    HWRITE = 1'b1;
    HADDR  = 32'h04;
    cyc();
    HWDATA = 32'hDEAD_BEEF;
    bus_idle();
    cyc();
    bus_read(32'h04, rd); check("idle_no_write", rd, 32'h1234);
    bus_write(32'h08, 32'h55);
    bus_read(32'h08, rd); check("value_ro", rd, 32'h1234);
    bus_write(32'h0C, 32'hFFFF_FFFF);
    bus_read(32'h0C, rd); check("prescale_width", rd, 32'h0000_FFFF);
    bus_write(32'h00, 32'hFFFF_FFF8);
    bus_read(32'h00, rd); check("ctrl_upper_zero", rd, 32'd0);

    // LOAD write on a tick edge: no decrement that edge
    bus_write(32'h0C, 32'd0);
    bus_write(32'h00, 32'd1);
    addr_phase(32'h04, 1'b1);
    cyc();
    HWDATA = 32'd10;
    addr_phase(32'h08, 1'b0);
    cyc();
    bus_idle();
    check("load_wins_tick", HRDATA, 32'd10);
    bus_write(32'h00, 32'd0);

`ifdef TIMER_PWM_EN
    bus_write(32'h04, 32'd9);
    bus_write(32'h14, 32'd4);
    bus_read(32'h14, rd); check("compare_rd", rd, 32'd4);
    bus_write(32'h00, 32'd1);
    repeat (5) cyc();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (PWM_OUT) cnt++;
    end
    check("pwm_duty", 32'(cnt), 32'd8);
`else
    bus_write(32'h14, 32'd4);
    bus_read(32'h14, rd); check("compare_absent", rd, 32'd0);
    bus_write(32'h04, 32'd9);
    bus_write(32'h00, 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (PWM_OUT) cnt++;
    end
    check("pwm_absent", 32'(cnt), 32'd0);
`endif
    bus_write(32'h00, 32'd0);
    check("end_hreadyout", 32'(HREADYOUT), 32'd1);
    check("end_hresp", 32'(HRESP), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_timer.md
Name: ahb_lite_timer

Overview:
- Zero-wait-state AHB-Lite slave: a programmable down-counting timer with prescaler, reload and interrupt output.
- Sits downstream of the system AHB-Lite decoder/slave mux on a spare device slot, alongside the RAM, GPIO, UART, HDMI and digit slaves.
- Gives firmware periodic and one-shot time bases. IRQ goes to the core interrupt line.

Parameters:
- PRESCALE_WIDTH, 16: width of PRESCALE register/counter (1..32).
- RST_LOAD, 32'h0000_0000: reset value of LOAD and VALUE.

Ports:
- HCLK  in  1  system clock; all logic rising-edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  address; only HADDR[4:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means valid.
- HSIZE  in  3  ignored; all accesses treated as 32-bit.
- HPROT  in  4  ignored.
- HWRITE  in  1  write strobe.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus ready from mux.
- HRDATA  out  32  read data (data phase).
- HREADYOUT  out  1  constant 1.
- HRESP  out  1  constant 0 (OKAY).
- IRQ  out  1  IF & IRQ_EN.
- PWM_OUT  out  1  PWM output; constant 0 unless TIMER_PWM_EN.

Behaviour:
- Reset (HRESET=1 at HCLK edge):
  - CTRL=0, PRESCALE=0, prescale counter=0, IF=0.
  - LOAD=VALUE=RST_LOAD; address-phase regs cleared.
  - IRQ=0, PWM_OUT=0.
  - Reset mid-count aborts immediately; no IF pulse.
- Address phase: when HSEL & HREADY & HTRANS[1], register HADDR[4:2] and HWRITE; otherwise registered valid=0.
- Write data phase (one cycle after address phase): registered valid & write commits HWDATA at the end of that cycle.
- Read data phase: HRDATA is a combinational function of registered address and current register state.
  - Unmapped offsets read 0; writes to them are ignored.
- Register map (byte offset):
  - 0x00 CTRL: [0] EN, [1] IRQ_EN, [2] ONESHOT; other bits read 0.
  - 0x04 LOAD: reload value (R/W).
    - Writing LOAD also sets VALUE=new value and clears the prescale counter in the same edge.
  - 0x08 VALUE: current count (RO; writes ignored).
  - 0x0C PRESCALE: divider; tick every PRESCALE+1 HCLK cycles (R/W, upper bits read 0).
  - 0x10 STATUS: [0] IF; write 1 clears, write 0 has no effect.
  - 0x14 COMPARE: only with TIMER_PWM_EN, else reads 0.
- Tick generation:
  - While EN=1, the prescale counter increments each cycle.
  - When it equals PRESCALE: tick=1 and the counter returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds both counters frozen.
- On tick:
  - VALUE!=0: VALUE-=1.
  - VALUE==0: IF=1 and VALUE=LOAD. If ONESHOT=1, also EN=0 and VALUE stays 0.
  - Period is (LOAD+1)*(PRESCALE+1) cycles. LOAD=0 sets IF every tick.
- Collisions on the same edge:
  - Hardware IF set and STATUS W1C: set wins, IF stays 1.
  - LOAD write and tick: the write wins, and no decrement happens that edge.
  - CTRL write clearing EN and tick: the tick is processed; EN=0 takes effect from the next edge.
- IRQ is registered-level: IRQ = IF & IRQ_EN. It stays high until IF is cleared or IRQ_EN=0.
- Back-to-back transfers are supported (pipelined address/data). A read of a register written in the previous data phase returns the new value.

Optional Feature:
- Macro: TIMER_PWM_EN.
- Defined:
  - Adds COMPARE register at 0x14 (R/W, reset 0).
  - PWM_OUT is registered: PWM_OUT=1 when EN=1 and VALUE<COMPARE, else 0. It updates one cycle after VALUE changes.
  - COMPARE>LOAD gives constant 1 while enabled; COMPARE=0 gives constant 0.
- Undefined: no COMPARE storage, 0x14 reads 0 and ignores writes, PWM_OUT tied to 0.

Test Plan:
- Reset checks:
  - Assert HRESET 3 cycles mid-count with LOAD=5 running -> all registers read reset values (VALUE=RST_LOAD, CTRL=0, STATUS=0), IRQ=0.
  - HREADYOUT=1 and HRESP=0 throughout.
- Periodic timer:
  - Write LOAD=3, PRESCALE=1, CTRL=0x3 -> VALUE sequence 3,3,2,2,1,1,0,0 then reload 3.
  - IF/IRQ rise on the edge where VALUE 0 reloads, i.e. 8 cycles after EN.
  - Period is 8 cycles.
- One-shot: LOAD=2, PRESCALE=0, CTRL=0x7 -> VALUE 2,1,0; IF=1 on the 3rd tick; CTRL reads 0x6; VALUE holds 0.
- Clear collision: with IF pending, write STATUS=1 on the same edge as the next underflow (LOAD=0, PRESCALE=0) -> IF stays 1. Write STATUS=1 with EN=0 -> IF=0, IRQ=0 next cycle.
- Bus pipelining:
  - Back-to-back write LOAD=0x1234 then read LOAD -> HRDATA=0x0000_1234.
  - Read 0x18 -> 0.
  - HTRANS=IDLE with HSEL=1 and HWRITE=1 -> no register change.
- PWM (TIMER_PWM_EN defined): LOAD=9, PRESCALE=0, COMPARE=4, EN=1 -> PWM_OUT high 4 of every 10 cycles. Without the macro -> PWM_OUT=0 and 0x14 reads 0.
